// File: rtl/pipelined_instruction_decoder.sv
// pipelined_instruction_decoder: registered RV32I decode stage with valid/ready handshake,
// illegal/parity detection and a saturating error counter
module pipelined_instruction_decoder #(
    parameter int XLEN      = 32,
    parameter bit PARITY_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             in_parity,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_class,
    output logic [3:0]       out_alu_op,
    output logic [2:0]       out_funct3,
    output logic [4:0]       out_rd,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic             out_parity_err,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, SLL = 4'd2, SLT = 4'd3, SLTU = 4'd4,
                           XOR = 4'd5, SRL = 4'd6, SRA = 4'd7, OR = 4'd8, AND = 4'd9,
                           PASS_B = 4'd10;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [8:0]  cls;
    logic [3:0]  alu_rr, alu;
    logic [31:0] imm;
    logic        illegal, perr, accept;
    assign op = in_instr[6:0];
    assign f3 = in_instr[14:12];
    assign f7 = in_instr[31:25];
    assign cls = {op == 7'h17, op == 7'h37, op == 7'h67, op == 7'h6F, op == 7'h63,
                  op == 7'h23, op == 7'h03, op == 7'h13, op == 7'h33};
    // the opcode compares include instr[1:0], so a non-32-bit encoding never matches a class
    assign illegal = (cls == 9'd0)
        || (cls[0] && !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))))
        || (cls[1] && ((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20)))
        || (cls[2] && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7))
        || (cls[3] && f3 > 3'd2)
        || (cls[4] && (f3 == 3'd2 || f3 == 3'd3))
        || (cls[6] && f3 != 3'd0);
    assign perr   = PARITY_EN && ((^in_instr) != in_parity);
    assign accept = in_valid && in_ready;
    assign in_ready = !out_valid || out_ready;
    always_comb begin
        case (f3)
            3'd0:    alu_rr = (cls[0] && f7[5]) ? SUB : ADD;
            3'd1:    alu_rr = SLL;
            3'd2:    alu_rr = SLT;
            3'd3:    alu_rr = SLTU;
            3'd4:    alu_rr = XOR;
            3'd5:    alu_rr = f7[5] ? SRA : SRL;
            3'd6:    alu_rr = OR;
            default: alu_rr = AND;
        endcase
        alu = illegal ? ADD : (cls[0] || cls[1]) ? alu_rr : cls[4] ? SUB : cls[7] ? PASS_B : ADD;
        imm = illegal ? 32'd0
            : (cls[1] || cls[2] || cls[6]) ? {{20{in_instr[31]}}, in_instr[31:20]}
            : cls[3] ? {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]}
            : cls[4] ? {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}
            : (cls[7] || cls[8]) ? {in_instr[31:12], 12'd0}
            : cls[5] ? {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}
            : 32'd0;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_class      <= '0;
            out_alu_op     <= '0;
            out_funct3     <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_imm        <= '0;
            out_illegal    <= 1'b0;
            out_parity_err <= 1'b0;
            err_cnt        <= '0;
        end else begin
            out_valid <= !flush && (accept || (out_valid && !out_ready));
            if (accept && !flush) begin
                out_class      <= illegal ? 9'd0 : cls;
                out_alu_op     <= alu;
                out_funct3     <= f3;
                out_rd         <= in_instr[11:7];
                out_rs1        <= in_instr[19:15];
                out_rs2        <= in_instr[24:20];
                out_imm        <= XLEN'($signed(imm));
                out_illegal    <= illegal;
                out_parity_err <= perr;
                if ((illegal || perr) && err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end
endmodule
